// File: rtl/disp_formatter_pkg.sv
// Shared types and constants for the display formatter: FSM state encoding,
// seven-segment glyphs (bit0..6 = a..g, bit7 = dp, active-high) and the
// binary-to-BCD conversion constants.
package disp_formatter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_ENCODE  = 3'd2,
    ST_ARM     = 3'd3,
    ST_STROBE  = 3'd4,
    ST_WAIT    = 3'd5
  } state_e;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int unsigned VALUE_W     = 14;
  localparam int unsigned MAX_VALUE   = 9999;
  localparam int unsigned CONV_CYCLES = 14;

  // Map one BCD digit to its segment glyph; non-decimal codes show blank.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/disp_formatter_if.sv
// Value/handshake bundle between the value producer, the formatter and the
// downstream display driver. The formatter uses the slave modport.
interface disp_formatter_if;
  logic [13:0]     value_i;
  logic            value_valid_i;
  logic            ready_o;
  logic [3:0][7:0] digits_o;
  logic            disp_strobe_o;
  logic            busy_i;

  modport slave (
    input  value_i, value_valid_i, busy_i,
    output ready_o, digits_o, disp_strobe_o
  );

  modport master (
    output value_i, value_valid_i, busy_i,
    input  ready_o, digits_o, disp_strobe_o
  );
endinterface

// File: rtl/disp_formatter_bin2bcd.sv
// Sequential shift-add-3 (double dabble) converter: one bit per cycle,
// CONV_CYCLES cycles after start. done_o flags the cycle of the final shift,
// so the BCD outputs are complete from the following cycle on.
module bin2bcd
  import disp_formatter_pkg::*;
(
  input  logic        clk_i,
  input  logic        porb_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [13:0] bin_i,
  output logic        done_o,
  output logic [3:0]  thou_o,
  output logic [3:0]  hund_o,
  output logic [3:0]  tens_o,
  output logic [3:0]  units_o
);

  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt_q;
  logic        run_q;

  // Add 3 to every BCD digit that would exceed 9 after the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD register per cycle.
  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (clear_i) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= 4'(CONV_CYCLES);
      run_q <= 1'b1;
    end else if (run_q) begin
      {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
      cnt_q          <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) run_q <= 1'b0;
    end
  end

  assign done_o  = run_q && (cnt_q == 4'd1);
  assign thou_o  = bcd_q[15:12];
  assign hund_o  = bcd_q[11:8];
  assign tens_o  = bcd_q[7:4];
  assign units_o = bcd_q[3:0];

endmodule

// File: rtl/disp_formatter.sv
// Four-digit seven-segment formatter: captures a 14-bit value, converts it to
// BCD, encodes the segment pattern (dashes on overflow) and hands it to the
// display driver with a strobe/busy handshake.
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank leading zero digits
// (units digit always shown, overflow dashes unaffected).
module disp_formatter
  import disp_formatter_pkg::*;
(
  input  logic              clk_i,
  input  logic              porb_i,
  input  logic              sync_reset_i,
  disp_formatter_if.slave   bus
);

  state_e          state_q, state_d;
  logic            overflow_q;
  logic [3:0][7:0] digits_q, digits_d;
  logic            strobe_q;
  logic            start;
  logic            conv_done;
  logic [3:0]      thou, hund, tens, units;

  assign start = (state_q == ST_IDLE) && bus.value_valid_i;

  bin2bcd u_bin2bcd (
    .clk_i   (clk_i),
    .porb_i  (porb_i),
    .clear_i (sync_reset_i),
    .start_i (start),
    .bin_i   (bus.value_i),
    .done_o  (conv_done),
    .thou_o  (thou),
    .hund_o  (hund),
    .tens_o  (tens),
    .units_o (units)
  );

  // Next-state logic for the capture / convert / handshake sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.value_valid_i) state_d = ST_CONVERT;
      ST_CONVERT: if (conv_done)         state_d = ST_ENCODE;
      ST_ENCODE:                         state_d = ST_ARM;
      ST_ARM:     if (!bus.busy_i)       state_d = ST_STROBE;
      ST_STROBE:  if (bus.busy_i)        state_d = ST_WAIT;
      ST_WAIT:    if (!bus.busy_i)       state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Segment patterns from the finished BCD digits; leading zeros optionally blanked.
  always_comb begin
    if (overflow_q) begin
      digits_d = {4{SEG_DASH}};
    end else begin
      digits_d[0] = seg_of(thou);
      digits_d[1] = seg_of(hund);
      digits_d[2] = seg_of(tens);
      digits_d[3] = seg_of(units);
`ifdef LEADING_ZERO_BLANK_EN
      if (thou == 4'd0)                                 digits_d[0] = SEG_BLANK;
      if (thou == 4'd0 && hund == 4'd0)                 digits_d[1] = SEG_BLANK;
      if (thou == 4'd0 && hund == 4'd0 && tens == 4'd0) digits_d[2] = SEG_BLANK;
`endif
    end
  end

  // State, overflow flag, displayed digits and strobe; both resets abandon any operation.
  // The strobe is raised one cycle into STROBE and dropped on the edge busy is seen.
  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      digits_q   <= {4{SEG_BLANK}};
      strobe_q   <= 1'b0;
    end else if (sync_reset_i) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      digits_q   <= {4{SEG_BLANK}};
      strobe_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= (state_q == ST_STROBE) && !bus.busy_i;
      if (start)                   overflow_q <= (bus.value_i > 14'(MAX_VALUE));
      if (state_q == ST_ENCODE)    digits_q   <= digits_d;
    end
  end

  assign bus.ready_o       = (state_q == ST_IDLE);
  assign bus.digits_o      = digits_q;
  assign bus.disp_strobe_o = strobe_q;

endmodule

// File: tb/tb_disp_formatter.sv
// Directed bench for disp_formatter: table of values with hand-computed
// segment patterns, plus sequences for back-pressure, resets and ignored input.
module tb_disp_formatter;
  import disp_formatter_pkg::*;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic porb_i;
  logic sync_reset_i;

  disp_formatter_if dif ();

  disp_formatter dut (
    .clk_i        (clk_i),
    .porb_i       (porb_i),
    .sync_reset_i (sync_reset_i),
    .bus          (dif)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [13:0] value;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] mk(input logic [7:0] th, h, t, u);
    mk = {u, t, h, th};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic capture(input string name, input logic [13:0] v);
    int n = 0;
    while (!dif.ready_o && n < 50) begin
      step();
      n++;
    end
    check({name, " ready before capture"}, 32'(dif.ready_o), 32'd1);
    dif.value_i       = v;
    dif.value_valid_i = 1'b1;
    step();
    dif.value_valid_i = 1'b0;
  endtask

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    while (!dif.disp_strobe_o && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic watch_no_strobe(input string name, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (dif.disp_strobe_o) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic run_vec(input string name, input logic [13:0] v, input logic [31:0] exp);
    int cyc;
    capture(name, v);
    wait_strobe(cyc);
    check({name, " strobe latency"}, 32'(cyc), 32'd17);
    check({name, " digits"}, dif.digits_o, exp);
    repeat (3) step();
    check({name, " strobe held"}, 32'(dif.disp_strobe_o), 32'd1);
    dif.busy_i = 1'b1;
    step();
    check({name, " strobe drop"}, 32'(dif.disp_strobe_o), 32'd0);
    check({name, " ready in wait"}, 32'(dif.ready_o), 32'd0);
    dif.busy_i = 1'b0;
    step();
    check({name, " ready after wait"}, 32'(dif.ready_o), 32'd1);
  endtask

  initial begin
    int cyc;
    porb_i            = 1'b0;
    sync_reset_i      = 1'b0;
    dif.value_i       = '0;
    dif.value_valid_i = 1'b0;
    dif.busy_i        = 1'b0;

    vecs[0] = '{"v2025",  14'd2025,  mk(SEG_2, SEG_0, SEG_2, SEG_5)};
    vecs[1] = '{"v0",     14'd0,     LZB ? mk(SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0)
                                         : mk(SEG_0, SEG_0, SEG_0, SEG_0)};
    vecs[2] = '{"v9999",  14'd9999,  mk(SEG_9, SEG_9, SEG_9, SEG_9)};
    vecs[3] = '{"v10000", 14'd10000, mk(SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH)};
    vecs[4] = '{"v16383", 14'd16383, mk(SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH)};
    vecs[5] = '{"v42",    14'd42,    LZB ? mk(SEG_BLANK, SEG_BLANK, SEG_4, SEG_2)
                                         : mk(SEG_0, SEG_0, SEG_4, SEG_2)};
    vecs[6] = '{"v305",   14'd305,   LZB ? mk(SEG_BLANK, SEG_3, SEG_0, SEG_5)
                                         : mk(SEG_0, SEG_3, SEG_0, SEG_5)};
    vecs[7] = '{"v1000",  14'd1000,  mk(SEG_1, SEG_0, SEG_0, SEG_0)};
    vecs[8] = '{"v7",     14'd7,     LZB ? mk(SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_7)
                                         : mk(SEG_0, SEG_0, SEG_0, SEG_7)};

    // Reset state
    #12;
    check("reset digits", dif.digits_o, {4{SEG_BLANK}});
    check("reset strobe", 32'(dif.disp_strobe_o), 32'd0);
    check("reset ready", 32'(dif.ready_o), 32'd1);
    @(posedge clk_i);
    #3 porb_i = 1'b1;
    step();
    check("ready after release", 32'(dif.ready_o), 32'd1);

    // Table of values
    for (int i = 0; i < 9; i++) run_vec(vecs[i].name, vecs[i].value, vecs[i].exp);

    // Downstream busy through ENCODE: hold in ARM, then strobe, then 5-cycle busy pulse
    dif.busy_i = 1'b1;
    capture("armbusy", 14'd1234);
    watch_no_strobe("armbusy no strobe while busy", 25);
    check("armbusy ready", 32'(dif.ready_o), 32'd0);
    check("armbusy digits", dif.digits_o, mk(SEG_1, SEG_2, SEG_3, SEG_4));
    dif.busy_i = 1'b0;
    step();
    step();
    check("armbusy strobe after fall", 32'(dif.disp_strobe_o), 32'd1);
    dif.busy_i = 1'b1;
    step();
    check("armbusy strobe drop", 32'(dif.disp_strobe_o), 32'd0);
    repeat (4) step();
    check("armbusy ready during pulse", 32'(dif.ready_o), 32'd0);
    dif.busy_i = 1'b0;
    step();
    check("armbusy ready after fall", 32'(dif.ready_o), 32'd1);

    // Asynchronous reset in the middle of a conversion
    capture("asyncrst", 14'd5678);
    repeat (7) step();
    porb_i = 1'b0;
    #1;
    check("asyncrst digits", dif.digits_o, {4{SEG_BLANK}});
    check("asyncrst strobe", 32'(dif.disp_strobe_o), 32'd0);
    check("asyncrst ready", 32'(dif.ready_o), 32'd1);
    #2 porb_i = 1'b1;
    watch_no_strobe("asyncrst no strobe", 30);
    run_vec("post_rst_v42", 14'd42, LZB ? mk(SEG_BLANK, SEG_BLANK, SEG_4, SEG_2)
                                       : mk(SEG_0, SEG_0, SEG_4, SEG_2));

    // Synchronous reset while strobing
    capture("syncrst", 14'd9999);
    wait_strobe(cyc);
    check("syncrst strobe reached", 32'(cyc), 32'd17);
    sync_reset_i = 1'b1;
    dif.value_valid_i = 1'b1;
    dif.value_i = 14'd1;
    step();
    sync_reset_i = 1'b0;
    dif.value_valid_i = 1'b0;
    check("syncrst strobe", 32'(dif.disp_strobe_o), 32'd0);
    check("syncrst digits", dif.digits_o, {4{SEG_BLANK}});
    check("syncrst ready", 32'(dif.ready_o), 32'd1);
    watch_no_strobe("syncrst no strobe", 30);

    // value_valid_i during WAIT is ignored
    capture("waitvalid", 14'd2025);
    wait_strobe(cyc);
    dif.busy_i = 1'b1;
    step();
    dif.value_i       = 14'd7;
    dif.value_valid_i = 1'b1;
    step();
    dif.value_valid_i = 1'b0;
    check("waitvalid ready in wait", 32'(dif.ready_o), 32'd0);
    dif.busy_i = 1'b0;
    step();
    check("waitvalid ready idle", 32'(dif.ready_o), 32'd1);
    check("waitvalid digits", dif.digits_o, mk(SEG_2, SEG_0, SEG_2, SEG_5));
    watch_no_strobe("waitvalid nothing queued", 25);
    check("waitvalid digits later", dif.digits_o, mk(SEG_2, SEG_0, SEG_2, SEG_5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_formatter.md
DISP_FORMATTER -- requirements
Module: disp_formatter

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset; the clock is clk_i, the reset is porb_i.
REQ-002 clk_i  input  1  system clock; all logic rising-edge.
REQ-003 porb_i  input  1  asynchronous active-low reset.
REQ-004 sync_reset_i  input  1  synchronous active-high reset.
REQ-005 value_i  input  14  unsigned binary number to display.
REQ-006 value_valid_i  input  1  value_i is valid.
REQ-007 ready_o  output  1  module accepts a new value.
REQ-008 digits_o  output  4x8  segment codes; [0]=thousands, [3]=units; bit0..6=a..g, bit7=dp, active-high.
REQ-009 disp_strobe_o  output  1  request to the downstream display driver to send digits_o.
REQ-010 busy_i  input  1  downstream driver busy.

Function
REQ-011 States SHALL be IDLE, CONVERT, ENCODE, ARM, STROBE, WAIT.
REQ-012 IDLE: ready_o=1; on value_valid_i=1, capture value_i and go to CONVERT; ready_o SHALL be 0 in all other states.
REQ-013 value_valid_i outside IDLE SHALL be ignored (no capture, no queuing).
REQ-014 CONVERT SHALL run a sequential shift-add-3 binary-to-BCD conversion for exactly 14 cycles, then go to ENCODE.
REQ-015 ENCODE (1 cycle) SHALL register digits_o from the BCD result and go to ARM.
REQ-016 A captured value > 9999 SHALL set an overflow flag; ENCODE SHALL then drive SEG_DASH on all four digits.
REQ-017 ARM SHALL wait until busy_i=0, then go to STROBE.
REQ-018 STROBE SHALL hold disp_strobe_o=1 until busy_i=1 is sampled, then go to WAIT with disp_strobe_o=0 next cycle.
REQ-019 WAIT SHALL remain until busy_i=0, then return to IDLE.
REQ-020 With busy_i held 0 from capture, disp_strobe_o SHALL first assert exactly 17 cycles after the capture edge.
REQ-021 digits_o SHALL stay constant from the ENCODE edge until the next ENCODE edge or reset.
REQ-022 disp_strobe_o SHALL never assert outside STROBE.

Reset
REQ-023 porb_i=0 SHALL immediately force IDLE, digits_o all SEG_BLANK, disp_strobe_o=0, overflow=0, BCD state cleared.
REQ-024 sync_reset_i=1 SHALL give the same state at the next edge, with priority over all other inputs.
REQ-025 Reset in any state, including mid-CONVERT or mid-STROBE, SHALL abandon the operation with no further strobe.
REQ-026 After reset release, ready_o SHALL be 1.

Configuration
REQ-027 With LEADING_ZERO_BLANK_EN defined, leading zero digits SHALL be SEG_BLANK; the units digit is always shown; overflow dashes are unaffected.
REQ-028 Without LEADING_ZERO_BLANK_EN, all four digits SHALL be shown, including leading zeros.

Structure
REQ-029 Package disp_formatter_pkg SHALL hold:
- the state enum;
- SEG_0..SEG_9 (3F,06,5B,4F,66,6D,7D,07,7F,6F hex);
- SEG_DASH=8'h40 and SEG_BLANK=8'h00;
- the constants MAX_VALUE=9999 and CONV_CYCLES=14.
REQ-030 Conversion SHALL live in sub-module bin2bcd (start, 14-bit in, done, four 4-bit BCD out); segment encoding stays in disp_formatter.

Verification
REQ-031 value_i=2025, valid 1 cycle, busy_i=0 -> strobe at capture+17; digits_o = SEG_2, SEG_0, SEG_2, SEG_5; strobe held until busy_i=1.
REQ-032 value_i=0 -> with macro: BLANK, BLANK, BLANK, SEG_0; without macro: SEG_0 x4.
REQ-033 value_i=10000 and value_i=16383 -> SEG_DASH x4; value_i=9999 -> SEG_9 x4.
REQ-034 busy_i=1 at ENCODE -> stays in ARM with no strobe; busy_i falls -> strobe next cycle; busy_i pulse 5 cycles -> IDLE and ready_o=1 one cycle after fall.
REQ-035 porb_i=0 at capture+7 (mid-CONVERT) -> digits_o blank, no strobe; after release, value 42 -> without macro: SEG_0, SEG_0, SEG_4, SEG_2.
REQ-036 value_valid_i pulsed with value 7 during WAIT -> ignored; digits_o unchanged; ready_o=0.
